// File: rtl/grostl_pkg.sv
// grostl_pkg: state type, ShiftBytes tables and round-constant helpers
// shared by the Grostl AddRoundConstant/SubBytes/ShiftBytes stage.
package grostl_pkg;

    typedef logic [0:7][0:7][7:0] state_t;

    localparam int NUM_ROUNDS = 10;

    localparam logic [0:7][2:0] SHIFT_P = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam logic [0:7][2:0] SHIFT_Q = {3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd2, 3'd4, 3'd6};

    // Row-0 constant of P for column j, round i.
    function automatic logic [7:0] rc_p(input logic [2:0] j, input logic [3:0] i);
        return {1'b0, j, 4'h0} ^ {4'h0, i};
    endfunction

    // Full row-7 mask of Q: the all-ones complement plus the column/round constant.
    function automatic logic [7:0] rc_q(input logic [2:0] j, input logic [3:0] i);
        return 8'hff ^ {1'b0, j, 4'h0} ^ {4'h0, i};
    endfunction

endpackage

// File: rtl/grostl_sbox.sv
// grostl_sbox: combinational AES S-box, one byte in, one byte out.
module grostl_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/grostl_sub_shift.sv
// grostl_sub_shift: column-serial AddRoundConstant + SubBytes + ShiftBytes for the
// Grostl-512 state, SBOX_COLS columns per cycle, P or Q selected per transaction.
module grostl_sub_shift
    import grostl_pkg::*;
#(
    parameter int SBOX_COLS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  state_t     i_din,
    input  logic       i_perm_q,
    input  logic [3:0] i_round,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output state_t     o_dout
);

    typedef enum logic [1:0] {IDLE, SUB, DONE} fsm_t;

    fsm_t       r_state, w_next;
    state_t     r_work, r_dout, w_dout;
    logic       r_q;
    logic [3:0] r_round;
    logic [2:0] r_col;
    logic       w_last;
    logic [7:0] w_sin  [SBOX_COLS][8];
    logic [7:0] w_sout [SBOX_COLS][8];
    logic [2:0] w_dst  [SBOX_COLS][8];

    assign w_last      = r_col == 3'(8 - SBOX_COLS);
    assign o_in_ready  = r_state == IDLE;
    assign o_out_valid = r_state == DONE;
    assign o_dout      = r_dout;

    for (genvar c = 0; c < SBOX_COLS; c++) begin : g_col
        logic [2:0] w_j;
        assign w_j = r_col + 3'(c);
        for (genvar r = 0; r < 8; r++) begin : g_row
            assign w_sin[c][r] = r_work[w_j][r] ^ (r_q ? (r == 7 ? rc_q(w_j, r_round) : 8'hff)
                                                       : (r == 0 ? rc_p(w_j, r_round) : 8'h00));
            // Left rotation by s moves source column j to destination column j - s.
            assign w_dst[c][r] = w_j - (r_q ? SHIFT_Q[r] : SHIFT_P[r]);
            grostl_sbox u_sbox (
                .i_byte(w_sin[c][r]),
                .o_byte(w_sout[c][r])
            );
        end
    end

    always_comb begin
        w_dout = r_dout;
        for (int i = 0; i < SBOX_COLS; i++)
            for (int j = 0; j < 8; j++)
                w_dout[w_dst[i][j]][j[2:0]] = w_sout[i][j];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_in_valid ? SUB : IDLE;
            SUB:     w_next = w_last ? DONE : SUB;
            DONE:    w_next = i_out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_q     <= 1'b0;
            r_round <= '0;
            r_col   <= '0;
            r_dout  <= '0;
        end else if (r_state == IDLE && i_in_valid) begin
            r_work  <= i_din;
            r_q     <= i_perm_q;
            r_round <= i_round;
            r_col   <= '0;
        end else if (r_state == SUB) begin
            r_col  <= r_col + 3'(SBOX_COLS);
            r_dout <= w_dout;
        end
    end

endmodule

// File: tb/tb_grostl_sub_shift.sv
// tb_grostl_sub_shift: table vectors, hand sequences and a random regression
// against an independent ARC+SubBytes+ShiftBytes model, with a scoreboard on DUT 0.
module tb_grostl_sub_shift;
    import grostl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_valid = '0;
    logic [3:0] out_ready = '1;
    logic [3:0] in_ready, out_valid;
    state_t     din = '0;
    logic       perm_q = 1'b0;
    logic [3:0] round = '0;
    state_t     dout [4];

    int checks = 0;
    int errors = 0;
    int accepts = 0;
    state_t sb [$];
    logic [7:0] sbt [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        grostl_sub_shift #(.SBOX_COLS(1 << g)) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .i_in_valid(in_valid[g]),
            .o_in_ready(in_ready[g]),
            .i_din(din),
            .i_perm_q(perm_q),
            .i_round(round),
            .o_out_valid(out_valid[g]),
            .i_out_ready(out_ready[g]),
            .o_dout(dout[g])
        );
    end

    task automatic check(input string name, input logic [519:0] act, input logic [519:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic state_t model(input state_t d, input logic q, input logic [3:0] i);
        state_t o;
        logic [7:0] b;
        int s;
        int sq [8];
        sq = '{1, 3, 5, 7, 0, 2, 4, 6};
        o = '0;
        for (int j = 0; j < 8; j++)
            for (int r = 0; r < 8; r++) begin
                b = d[j][r];
                if (q) b ^= 8'hff;
                if ((q && r == 7) || (!q && r == 0)) b ^= 8'(j * 16) ^ 8'(i);
                s = q ? sq[r] : r;
                o[(j - s + 8) % 8][r] = sbt[b];
            end
        return o;
    endfunction

    // Scoreboard: push on accept, pop and compare on output handshake (DUT 0 only).
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid[0] && in_ready[0]) begin
                sb.push_back(model(din, perm_q, round));
                accepts++;
            end
            if (out_valid[0] && out_ready[0]) begin
                if (sb.size() == 0) check("sb_underflow", 520'(sb.size()), 520'd1);
                else check("sb_dout", dout[0], sb.pop_front());
            end
        end
    end

    task automatic send(input int g, input state_t d, input logic q, input logic [3:0] r);
        int n;
        n = 0;
        while (!in_ready[g] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) check("in_ready_timeout", 520'(in_ready[g]), 520'd1);
        din = d;
        perm_q = q;
        round = r;
        in_valid[g] = 1'b1;
        @(posedge clk); #1;
        in_valid[g] = 1'b0;
    endtask

    task automatic wait_out(input int g, output int k);
        k = 0;
        while (!out_valid[g] && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic drain(input bit stall);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            if (stall) out_ready[0] = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
            n++;
        end
        out_ready[0] = 1'b1;
        if (n == 300) check("drain_timeout", 520'(sb.size()), 520'd0);
    endtask

    function automatic state_t rand_state();
        logic [511:0] t;
        for (int w = 0; w < 16; w++) t[w*32 +: 32] = $urandom();
        return t;
    endfunction

    typedef struct {
        string  name;
        state_t din;
        logic   q;
        logic [3:0] rnd;
        state_t exp;
    } vec_t;

    vec_t vt [3];
    logic [7:0] p_row0 [8] = '{8'h63, 8'hca, 8'hb7, 8'h04, 8'h09, 8'h53, 8'hd0, 8'h51};
    logic [7:0] q_row7 [8] = '{8'hdb, 8'h73, 8'h16, 8'hdf, 8'h9e, 8'h8a, 8'h08, 8'h79};

    initial begin
        state_t d, snap;
        int k, a0;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbt[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++) d[c][r] = 8'h8c + 8'(r);
        vt[0].name = "p_r0_zero"; vt[0].din = '0; vt[0].q = 1'b0; vt[0].rnd = 4'd0;
        vt[1].name = "q_r0_zero"; vt[1].din = '0; vt[1].q = 1'b1; vt[1].rnd = 4'd0;
        vt[2].name = "p_r3_8c";   vt[2].din = d;  vt[2].q = 1'b0; vt[2].rnd = 4'd3;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++) begin
                vt[0].exp[c][r] = r == 0 ? p_row0[c] : 8'h63;
                vt[1].exp[c][r] = r == 7 ? q_row7[c] : 8'h16;
            end
        vt[2].exp = model(d, 1'b0, 4'd3);

        #12;
        check("rst_in_ready", 520'(in_ready), 520'hf);
        check("rst_out_valid", 520'(out_valid), 520'h0);
        for (int g = 0; g < 4; g++) check("rst_dout", dout[g], 520'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold", {out_valid[0], in_ready[0], dout[0]}, {1'b0, 1'b1, 512'd0});

        foreach (vt[v]) begin
            send(0, vt[v].din, vt[v].q, vt[v].rnd);
            wait_out(0, k);
            check({vt[v].name, "_lat"}, 520'(k), 520'd8);
            check(vt[v].name, dout[0], vt[v].exp);
            drain(1'b0);
        end

        for (int g = 0; g < 4; g++) begin
            send(g, d, 1'b0, 4'd3);
            wait_out(g, k);
            check("cols_latency", 520'(k), 520'(8 >> g));
            check("cols_dout", dout[g], model(d, 1'b0, 4'd3));
            drain(1'b0);
            repeat (2) @(posedge clk);
            #1;
        end

        out_ready[0] = 1'b0;
        send(0, rand_state(), 1'b1, 4'd5);
        wait_out(0, k);
        snap = dout[0];
        in_valid[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            din = rand_state();
            @(posedge clk); #1;
            check("bp_hold", {out_valid[0], in_ready[0], dout[0]}, {1'b1, 1'b0, snap});
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 520'({out_valid[0], in_ready[0]}), 520'b01);
        check("bp_sb_empty", 520'(sb.size()), 520'd0);

        a0 = accepts;
        in_valid[0] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            din = rand_state();
            perm_q = 1'($urandom_range(0, 1));
            round = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        check("b2b_accepts", 520'(accepts - a0), 520'd3);
        drain(1'b0);

        send(0, rand_state(), 1'b0, 4'd7);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_async", {out_valid[0], in_ready[0], dout[0]}, {1'b0, 1'b1, 512'd0});
        @(posedge clk); #1;
        check("rst_mid_edge", {out_valid[0], in_ready[0], dout[0]}, {1'b0, 1'b1, 512'd0});
        rst_n = 1'b1;
        d = rand_state();
        send(0, d, 1'b1, 4'd9);
        wait_out(0, k);
        check("post_rst_lat", 520'(k), 520'd8);
        check("post_rst_q", dout[0], model(d, 1'b1, 4'd9));
        drain(1'b0);

        for (int n = 0; n < 1000; n++) begin
            send(0, rand_state(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, NUM_ROUNDS - 1)));
            drain(1'b1);
        end
        check("final_sb_empty", 520'(sb.size()), 520'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grostl_sub_shift.md
# grostl_sub_shift

Sequential AddRoundConstant + SubBytes + ShiftBytes stage for the Grøstl 512-bit (8×8 byte) state. It sits directly upstream of the MixBytes stage and hands it a complete, already-shifted state.
- SubBytes is column-serial, so S-box hardware (and its power signature) is limited to SBOX_COLS columns per cycle.
- The block supports both the P and Q permutations, selected per transaction.

## Interface
- SBOX_COLS, 1, columns substituted per cycle; legal values 1, 2, 4, 8.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  din/perm_q/round are valid.
- in_ready  out  1  block can accept a state (IDLE only).
- din  in  [0:7][0:7][7:0]  input state, indexed [column][row].
- perm_q  in  1  0 = P permutation, 1 = Q permutation.
- round  in  4  round index i, 0..9.
- out_valid  out  1  dout holds a finished state.
- out_ready  in  1  downstream (MixBytes register) accepts dout.
- dout  out  [0:7][0:7][7:0]  ARC→SubBytes→ShiftBytes result, indexed [column][row].

## Operation
- **FSM states:** IDLE, SUB, DONE.
  - IDLE: in_ready=1. On in_valid, capture din, perm_q and round into the work register, clear col_cnt, go to SUB.
  - SUB: each cycle processes columns col_cnt .. col_cnt+SBOX_COLS-1, then col_cnt += SBOX_COLS. After the last group (col_cnt wraps to 0), go to DONE.
  - DONE: out_valid=1. When out_ready=1, go to IDLE.
- **AddRoundConstant** for column j:
  - P: row 0 ^= {j[2:0], 1'b0} << 3 ^ round, i.e. byte (j<<4)^i. All other rows are unchanged.
  - Q: every byte ^= 0xff. Row 7 additionally ^= (j<<4)^i.
  - round is used as a 4-bit value with no range check. Values 10..15 produce their arithmetic constant.
- **SubBytes:** AES S-box applied to every byte after ARC.
- **ShiftBytes:** row r is rotated left by s_r. The substituted byte from source column j, row r is written to dout column (j − s_r) mod 8, row r.
  - P: s = {0,1,2,3,4,5,6,7}.
  - Q: s = {1,3,5,7,0,2,4,6}.
- dout is a register, written column-group by column-group during SUB. It is stable and complete for the whole of DONE.
- in_ready is held 0 in SUB and DONE, so there is no overlap between transactions. din changes outside IDLE are ignored.
- out_valid falls on the edge after the out_ready handshake. A new in_valid is accepted at the earliest in the following IDLE cycle.
- Reset at any time (including mid-SUB) aborts the transaction immediately. The partial result is discarded and the FSM returns to IDLE.

## Timing
- **Reset values:** FSM=IDLE, in_ready=1, out_valid=0, dout=0, col_cnt=0, work register=0.
- **Latency:** with N = 8/SBOX_COLS and the accept edge at T, SUB occupies edges T+1..T+N, and out_valid is high from edge T+N onward.
  - Default SBOX_COLS=1 gives 8 cycles of SUB.
- **Minimum transaction period:** N+2 cycles (accept, N SUB cycles, DONE handshake with out_ready tied high).
- out_ready low holds DONE indefinitely, with dout and out_valid stable.
- in_valid low in IDLE: the block stays in IDLE and all registers hold.

## Structure
- **grostl_pkg:**
  - state_t typedef ([0:7][0:7][7:0]).
  - shift tables SHIFT_P / SHIFT_Q.
  - rc_p(j,i) / rc_q(j,i) functions.
  - NUM_ROUNDS = 10.
- **Sub-module grostl_sbox:** combinational 8-bit AES S-box, one byte in and one byte out. It is instantiated 8×SBOX_COLS times, and the FSM muxes the current column group into it.
- The column-write / shift logic and the FSM stay in grostl_sub_shift.

## Test plan
- P, round 0, din=0, SBOX_COLS=1 → after 8 SUB cycles:
  - row 0 of dout, columns 0..7 = 63 ca b7 04 09 53 d0 51.
  - all other bytes = 0x63.
- Q, round 0, din=0 → dout row 7, columns 0..7 = db 73 16 df 9e 8a 08 79; all other bytes = 0x16.
- P, round 3, din[c][r] = 8c+r → dout matches the reference model for all 64 bytes. Repeat with SBOX_COLS = 2, 4, 8 and check out_valid rises exactly 8/SBOX_COLS cycles after accept.
- Backpressure:
  - hold out_ready=0 for 20 cycles in DONE → dout and out_valid stable, in_ready=0.
  - raise out_ready → out_valid drops next edge, in_ready=1.
  - back-to-back in_valid is accepted only in IDLE.
- Assert rst_n low at SUB cycle 4 → next edge shows in_ready=1, out_valid=0, dout=0. A fresh Q transaction afterwards produces a correct result.
- Random regression: 1000 random din/perm_q/round (0..9) vectors compared against the software ARC+SubBytes+ShiftBytes model, with random out_ready stalls.
